// File: rtl/fpu_div_iterative.sv
// FP16 divider using multi-cycle restoring division, truncating, with flush-to-zero on inputs and outputs.
// Optional FPU_DIV_EARLY_OUT_EN: special-case operands skip the DIV loop (2-cycle latency).
module fpu_div_iterative #(
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] result
);

    // state | meaning
    // IDLE  | ready for operands
    // PREP  | classify operands, set up exponent and remainder
    // DIV   | one restoring quotient bit per cycle (12 cycles)
    // NORM  | normalise or select special value, publish result
    typedef enum logic [1:0] {IDLE, PREP, DIV, NORM} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [14:0]        a_q, a_d;
    logic [14:0]        b_q, b_d;
    logic signed [6:0]  e_q, e_d;
    logic [11:0]        rem_q, rem_d;
    logic [11:0]        quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               special_q, special_d;
    logic [15:0]        spec_val_q, spec_val_d;
    logic               in_ready_q, in_ready_d;
    logic               valid_out_q, valid_out_d;
    logic [15:0]        res_q, res_d;

    logic [4:0]  a_exp, b_exp;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        spec_hit;
    logic [15:0] spec_val;
    logic [11:0] fb_ext, rem_sub;
    logic        rem_ge;
    logic signed [6:0] norm_exp;
    logic [9:0]  norm_man;
    logic        unused_upper;

    assign unused_upper = ^{a[31:16], b[31:16]};

    assign a_exp  = a_q[14:10];
    assign b_exp  = b_q[14:10];
    assign a_zero = (a_exp == 5'd0);
    assign b_zero = (b_exp == 5'd0);
    assign a_inf  = (a_exp == 5'h1F) && (a_q[9:0] == 10'd0);
    assign b_inf  = (b_exp == 5'h1F) && (b_q[9:0] == 10'd0);
    assign a_nan  = (a_exp == 5'h1F) && (a_q[9:0] != 10'd0);
    assign b_nan  = (b_exp == 5'h1F) && (b_q[9:0] != 10'd0);

    always_comb begin
        spec_hit = 1'b1;
        spec_val = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_val = QNAN;
        else if (a_inf || b_zero)
            spec_val = {sign_q, 5'h1F, 10'd0};
        else if (a_zero || b_inf)
            spec_val = {sign_q, 15'd0};
        else
            spec_hit = 1'b0;
    end

    // Remainder stays below 2*fb, so 12 bits suffice.
    assign fb_ext  = {2'b01, b_q[9:0]};
    assign rem_ge  = (rem_q >= fb_ext);
    assign rem_sub = rem_ge ? (rem_q - fb_ext) : rem_q;

    assign norm_exp = quo_q[11] ? e_q : (e_q - 7'sd1);
    assign norm_man = quo_q[11] ? quo_q[10:1] : quo_q[9:0];

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        a_d         = a_q;
        b_d         = b_q;
        e_d         = e_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        special_d   = special_q;
        spec_val_d  = spec_val_q;
        in_ready_d  = in_ready_q;
        valid_out_d = 1'b0;
        res_d       = res_q;
        case (state_q)
            IDLE: begin
                if (valid_in && in_ready_q) begin
                    sign_d     = a[15] ^ b[15];
                    a_d        = a[14:0];
                    b_d        = b[14:0];
                    in_ready_d = 1'b0;
                    state_d    = PREP;
                end
            end
            PREP: begin
                special_d  = spec_hit;
                spec_val_d = spec_val;
                e_d        = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 7'sd15;
                rem_d      = {2'b01, a_q[9:0]};
                quo_d      = 12'd0;
                cnt_d      = 4'd11;
                state_d    = DIV;
`ifdef FPU_DIV_EARLY_OUT_EN
                if (spec_hit)
                    state_d = NORM;
`endif
            end
            DIV: begin
                rem_d = {rem_sub[10:0], 1'b0};
                quo_d = {quo_q[10:0], rem_ge};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0)
                    state_d = NORM;
            end
            NORM: begin
                if (special_q)
                    res_d = spec_val_q;
                else if (norm_exp <= 7'sd0)
                    res_d = {sign_q, 15'd0};
                else if (norm_exp >= 7'sd31)
                    res_d = {sign_q, 5'h1F, 10'd0};
                else
                    res_d = {sign_q, norm_exp[4:0], norm_man};
                valid_out_d = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            a_q         <= 15'd0;
            b_q         <= 15'd0;
            e_q         <= 7'sd0;
            rem_q       <= 12'd0;
            quo_q       <= 12'd0;
            cnt_q       <= 4'd0;
            special_q   <= 1'b0;
            spec_val_q  <= 16'd0;
            in_ready_q  <= 1'b1;
            valid_out_q <= 1'b0;
            res_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            a_q         <= a_d;
            b_q         <= b_d;
            e_q         <= e_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            special_q   <= special_d;
            spec_val_q  <= spec_val_d;
            in_ready_q  <= in_ready_d;
            valid_out_q <= valid_out_d;
            res_q       <= res_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign valid_out = valid_out_q;
    assign result    = {16'd0, res_q};

endmodule

// File: doc/fpu_div_iterative.md
# fpu_div_iterative

IEEE 754 half-precision (FP16) divider, the inverse operator companion to the team's pipelined FP16 multiplier in the TinyQV FPU. It uses a multi-cycle restoring division with a ready/valid input handshake, so it is much smaller than a pipelined array divider. It keeps the FPU's 32-bit operand/result interface: operands are in bits [15:0] and the upper result bits are zero. Rounding is truncation, matching the multiplier.

## Interface
- `QNAN`, default 16'h7E00: canonical quiet-NaN pattern emitted for every invalid result.
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_in` input 1: operands valid; accepted only when `in_ready`=1.
- `in_ready` output 1: high only in IDLE; reset value 1.
- `a` input 32: dividend; [15:0] used, [31:16] ignored.
- `b` input 32: divisor; [15:0] used, [31:16] ignored.
- `valid_out` output 1: one-cycle pulse when `result` is updated; reset value 0.
- `result` output 32: {16'b0, fp16 quotient}; holds its value until the next completion; reset value 0.

## Operation
- FSM states: IDLE → PREP → DIV → NORM → IDLE.
- IDLE, when `valid_in` & `in_ready`:
  - latch sign = a[15]^b[15], exponents, and fractions fa/fb = {1, mant}.
  - go to PREP.
- PREP: classify the latched operands.
  - Subnormal inputs (exp=0) are flushed to zero.
  - Special-case priority:
    1. NaN input, 0/0, or inf/inf → `QNAN`.
    2. inf/x, or x/0 with x≠0 → {sign, 5'h1F, 10'b0}.
    3. 0/x or x/inf → {sign, 15'b0}.
  - Compute signed 7-bit exponent e = ea − eb + 15.
  - Initialise remainder = fa, quotient = 0, counter = 11.
  - Go to DIV.
- DIV: one restoring step per cycle, 12 steps in total, producing q = floor(fa·2^11 / fb), 12 bits, range 1024..4094.
  - Each step: if rem ≥ fb, then q bit = 1 and rem −= fb; then rem <<= 1.
  - Counter decrements each step; at 0, go to NORM.
- NORM, normalisation:
  - If q[11]=1: mant = q[10:1], exp = e.
  - Otherwise: mant = q[9:0], exp = e − 1.
  - Final exp ≤ 0 → signed zero (flush-to-zero, no subnormal output).
  - Final exp ≥ 31 → signed inf.
  - Write `result`, pulse `valid_out`, return to IDLE.
- If a special case was flagged in PREP, NORM outputs the special value instead of the quotient.
- `valid_in` while `in_ready`=0 is ignored; operands are not queued.

## Timing
- The acceptance edge is E0. The PREP registers update at E1, DIV runs on E2..E13, and NORM updates at E14.
- `valid_out`=1 in the cycle after E14, so latency is 14 cycles.
- `in_ready` returns to 1 in the same cycle `valid_out` is high. The next acceptance is at E15 at the earliest, giving throughput of one operation per 15 cycles.
- Reset mid-operation: the in-flight operation is dropped with no `valid_out`. The FSM goes to IDLE, `result`=0, and `in_ready`=1 in the cycle after the reset edge.
- `rst` takes priority over `valid_in` on the same edge.

## Configuration
- `FPU_DIV_EARLY_OUT_EN` defined:
  - Any special case or zero operand detected in PREP goes directly to NORM, skipping DIV. Latency is 2 cycles, with `valid_out` after E2.
  - Finite nonzero operands still take 14 cycles.
- `FPU_DIV_EARLY_OUT_EN` undefined: latency is always 14 cycles. Special cases still run DIV, and the quotient is discarded.

## Test plan
- 3.0/1.5: a=0x4200, b=0x3E00 → result 0x00004000; `valid_out` 14 cycles after acceptance; `in_ready` low throughout.
- 1.0/3.0: a=0x3C00, b=0x4200 → 0x00003555 (truncated); −6.0/2.0: a=0xC600, b=0x4000 → 0x0000C200.
- Special cases:
  - 0x3C00/0x0000 → 0x7C00.
  - 0x0000/0x0000 → 0x7E00.
  - 0xC000/0x7C00 → 0x8000.
  - 0x7E01/0x3C00 → 0x7E00.
  - Latency is 14 cycles without the macro and 2 cycles with it.
- Range: 0x7BFF/0x0400 → 0x7C00 (overflow); 0x0400/0x7BFF → 0x0000 (underflow flush); upper input bits 0xFFFF ignored.
- Handshake:
  - Assert `valid_in` continuously with changing operands; only operands present when `in_ready`=1 are used.
  - Back-to-back ops complete 15 cycles apart.
- Reset: assert `rst` at cycle 7 of an op → no `valid_out`; `result`=0; `in_ready`=1 the next cycle; a fresh op then completes correctly.
